// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage write enables,
// ID/EX bubble/flush, EX operand forwarding, load-use/redirect/memory-wait handling.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_we,
    input  logic       ex_link,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_we,
    input  logic       mem_link,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic       redirect,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       if_we,
    output logic       id_we,
    output logic       ex_we,
    output logic       mem_we,
    output logic       flush,
    output logic       bubble,
    output logic [2:0] fwd_a,
    output logic [2:0] fwd_b,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MWAIT   = 2'd3
    } state_t;

    localparam logic [1:0] LB_INIT = 2'(LOAD_BUBBLES - 1);
    localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES);

    state_t     st, saved_st, eff_st, nxt_st;
    logic [1:0] cnt, fcnt, nxt_cnt, nxt_fcnt;
    logic       in_reset;
    logic       mem_stall, load_use;
    logic [2:0] fwd_a_c, fwd_b_c, fwd_a_q, fwd_b_q;

    function automatic logic [2:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] e_rd,
        input logic       e_we,
        input logic       e_link,
        input logic       e_load,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic       m_link
    );
        if (e_we && !e_load && e_rd != '0 && e_rd == rs)
            return e_link ? 3'd1 : 3'd2;
        else if (m_we && m_rd != '0 && m_rd == rs)
            return m_link ? 3'd3 : 3'd4;
        else
            return 3'd0;
    endfunction

    assign fwd_a_c = fwd_sel(ex_rs1, ex_rd, ex_reg_we, ex_link, ex_mem_read,
                             mem_rd, mem_reg_we, mem_link);
    assign fwd_b_c = fwd_sel(ex_rs2, ex_rd, ex_reg_we, ex_link, ex_mem_read,
                             mem_rd, mem_reg_we, mem_link);

    assign mem_stall = dmem_req && !dmem_ready;
    assign load_use  = idex_mem_read && idex_rd != '0 &&
                       ((id_use_rs1 && idex_rd == id_rs1) ||
                        (id_use_rs2 && idex_rd == id_rs2));

    // While in MWAIT the interrupted state lives in saved_st; the release cycle acts as that state.
    assign eff_st = (st == MWAIT) ? saved_st : st;

    always_comb begin
        {if_we, id_we, ex_we, mem_we} = '1;
        flush    = 1'b0;
        bubble   = 1'b0;
        fwd_a    = fwd_a_c;
        fwd_b    = fwd_b_c;
        state    = eff_st;
        nxt_st   = eff_st;
        nxt_cnt  = cnt;
        nxt_fcnt = fcnt;
        if (in_reset) begin
            {if_we, id_we, ex_we, mem_we} = '0;
            flush = 1'b1;
            fwd_a = '0;
            fwd_b = '0;
            state = RUN;
        end else if (mem_stall) begin
            {if_we, id_we, ex_we, mem_we} = '0;
            state = MWAIT;
            if (st == MWAIT) begin
                fwd_a = fwd_a_q;
                fwd_b = fwd_b_q;
            end
        end else begin
            case (eff_st)
                RUN, LDSTALL: begin
                    if (redirect) begin
                        flush    = 1'b1;
                        nxt_fcnt = FC_INIT;
                        nxt_cnt  = '0;
                        nxt_st   = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
                    end else if (eff_st == LDSTALL) begin
                        {if_we, id_we} = '0;
                        bubble  = 1'b1;
                        nxt_cnt = cnt - 2'd1;
                        nxt_st  = (cnt <= 2'd1) ? RUN : LDSTALL;
                    end else if (load_use) begin
                        {if_we, id_we} = '0;
                        bubble  = 1'b1;
                        nxt_cnt = LB_INIT;
                        nxt_st  = (LOAD_BUBBLES > 1) ? LDSTALL : RUN;
                    end
                end
                FLUSH: begin
                    flush    = 1'b1;
                    nxt_fcnt = fcnt - 2'd1;
                    nxt_st   = (fcnt <= 2'd1) ? RUN : FLUSH;
                end
                default: nxt_st = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_reset <= 1'b1;
            st       <= RUN;
            saved_st <= RUN;
            cnt      <= '0;
            fcnt     <= '0;
            fwd_a_q  <= '0;
            fwd_b_q  <= '0;
        end else begin
            in_reset <= 1'b0;
            if (st != MWAIT) begin
                fwd_a_q <= fwd_a_c;
                fwd_b_q <= fwd_b_c;
            end
            if (!in_reset) begin
                if (mem_stall) begin
                    if (st != MWAIT) begin
                        saved_st <= st;
                        st       <= MWAIT;
                    end
                end else begin
                    st   <= nxt_st;
                    cnt  <= nxt_cnt;
                    fcnt <= nxt_fcnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: forwarding vector table plus multi-cycle hazard
// sequences, checked through an expected-output queue.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1, id_rs2;
        logic       id_use_rs1, id_use_rs2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_reg_we, ex_link, ex_mem_read;
        logic [4:0] mem_rd;
        logic       mem_reg_we, mem_link, idex_mem_read;
        logic [4:0] idex_rd;
        logic       redirect, dmem_req, dmem_ready;
    } in_t;

    typedef struct packed {
        logic [3:0] we;
        logic       flush, bubble;
        logic [2:0] fa, fb;
        logic [1:0] st;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic  clk = 1'b0;
    in_t   cur;
    out_t  act;
    logic  if_we, id_we, ex_we, mem_we, flush, bubble;
    logic [2:0] fwd_a, fwd_b;
    logic [1:0] state;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_BUBBLES(2), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(cur.rst),
        .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
        .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2),
        .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2), .ex_rd(cur.ex_rd),
        .ex_reg_we(cur.ex_reg_we), .ex_link(cur.ex_link), .ex_mem_read(cur.ex_mem_read),
        .mem_rd(cur.mem_rd), .mem_reg_we(cur.mem_reg_we), .mem_link(cur.mem_link),
        .idex_mem_read(cur.idex_mem_read), .idex_rd(cur.idex_rd),
        .redirect(cur.redirect), .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .if_we(if_we), .id_we(id_we), .ex_we(ex_we), .mem_we(mem_we),
        .flush(flush), .bubble(bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state)
    );

    assign act = {if_we, id_we, ex_we, mem_we, flush, bubble, fwd_a, fwd_b, state};

    function automatic in_t idle();
        in_t v;
        v = '0;
        v.rst = 1'b1;
        v.dmem_ready = 1'b1;
        return v;
    endfunction

    function automatic out_t mk(input logic [3:0] we, input logic fl, input logic bu,
                                input logic [2:0] fa, input logic [2:0] fb,
                                input logic [1:0] st);
        out_t o;
        o.we = we; o.flush = fl; o.bubble = bu; o.fa = fa; o.fb = fb; o.st = st;
        return o;
    endfunction

    function automatic out_t run_o(input logic [2:0] fa, input logic [2:0] fb);
        return mk(4'b1111, 1'b0, 1'b0, fa, fb, 2'd0);
    endfunction

    function automatic out_t ld_o(input logic [1:0] st);
        return mk(4'b0011, 1'b0, 1'b1, 3'd0, 3'd0, st);
    endfunction

    function automatic out_t fl_o(input logic [1:0] st);
        return mk(4'b1111, 1'b1, 1'b0, 3'd0, 3'd0, st);
    endfunction

    function automatic out_t wt_o(input logic [2:0] fa);
        return mk(4'b0000, 1'b0, 1'b0, fa, 3'd0, 2'd3);
    endfunction

    function automatic out_t rst_o();
        return mk(4'b0000, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0);
    endfunction

    task automatic check();
        out_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got we=%b fl=%b bu=%b fa=%0d fb=%0d st=%0d, want we=%b fl=%b bu=%b fa=%0d fb=%0d st=%0d",
                     n, act.we, act.flush, act.bubble, act.fa, act.fb, act.st,
                     e.we, e.flush, e.bubble, e.fa, e.fb, e.st);
        end
    endtask

    task automatic step(input string name, input in_t v, input out_t e);
        @(posedge clk);
        #2;
        cur = v;
        exp_q.push_back(e);
        name_q.push_back(name);
        #5;
        check();
    endtask

    task automatic add(input string name, input in_t v, input out_t e);
        vec_t r;
        r.name = name; r.in = v; r.exp = e;
        tbl.push_back(r);
    endtask

    in_t v, lu, rd, w, r;

    initial begin
        cur = idle();
        cur.rst = 1'b0;

        // Forwarding / no-stall vectors, all evaluated in RUN
        v = idle(); v.ex_reg_we = 1; v.ex_rd = 5; v.ex_rs1 = 5; v.ex_rs2 = 1;
        add("fwd_ex_alu", v, run_o(3'd2, 3'd0));
        v = idle(); v.ex_reg_we = 1; v.ex_link = 1; v.ex_rd = 1; v.ex_rs1 = 1;
        add("fwd_ex_pc_dist1", v, run_o(3'd1, 3'd0));
        v = idle(); v.mem_reg_we = 1; v.mem_link = 1; v.mem_rd = 1; v.ex_rs1 = 1;
        add("fwd_mem_pc_dist2", v, run_o(3'd3, 3'd0));
        v = idle(); v.mem_reg_we = 1; v.mem_rd = 9; v.ex_rs2 = 9;
        add("fwd_b_mem_alu", v, run_o(3'd0, 3'd4));
        v = idle(); v.ex_reg_we = 1; v.ex_rd = 3; v.mem_reg_we = 1; v.mem_rd = 3; v.ex_rs1 = 3;
        add("fwd_ex_priority", v, run_o(3'd2, 3'd0));
        v = idle(); v.ex_reg_we = 1; v.mem_reg_we = 1;
        add("fwd_x0_never", v, run_o(3'd0, 3'd0));
        v = idle(); v.ex_reg_we = 1; v.ex_mem_read = 1; v.ex_rd = 4; v.ex_rs1 = 4;
        v.mem_reg_we = 1; v.mem_rd = 4;
        add("fwd_load_skips_ex", v, run_o(3'd4, 3'd0));
        v = idle(); v.ex_rd = 6; v.ex_rs1 = 6; v.ex_rs2 = 6;
        add("fwd_no_we", v, run_o(3'd0, 3'd0));
        v = idle(); v.ex_reg_we = 1; v.ex_link = 1; v.ex_rd = 2; v.ex_rs2 = 2;
        v.mem_reg_we = 1; v.mem_rd = 8; v.ex_rs1 = 8;
        add("fwd_mixed", v, run_o(3'd4, 3'd1));
        v = idle(); v.idex_mem_read = 1; v.idex_rd = 7; v.id_rs1 = 7;
        add("lu_rs_unused", v, run_o(3'd0, 3'd0));
        v = idle(); v.idex_mem_read = 1; v.id_use_rs1 = 1;
        add("lu_x0", v, run_o(3'd0, 3'd0));

        lu = idle(); lu.idex_mem_read = 1; lu.idex_rd = 7; lu.id_rs1 = 7; lu.id_rs2 = 7;
        lu.id_use_rs1 = 1; lu.id_use_rs2 = 1;
        rd = idle(); rd.redirect = 1;
        w  = idle(); w.dmem_req = 1; w.dmem_ready = 0;
        r  = idle(); r.dmem_req = 1;

        v = idle(); v.rst = 1'b0;
        step("reset_hold", v, rst_o());
        step("reset_release", idle(), rst_o());
        step("run_after_reset", idle(), run_o(3'd0, 3'd0));

        foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

        // Load-use with two bubbles
        step("lu_detect", lu, ld_o(2'd0));
        step("lu_stall", idle(), ld_o(2'd1));
        step("lu_done", idle(), run_o(3'd0, 3'd0));
        v = idle(); v.idex_mem_read = 1; v.idex_rd = 9; v.id_rs2 = 9; v.id_use_rs2 = 1;
        step("lu_rs2_detect", v, ld_o(2'd0));
        step("lu_rs2_stall", idle(), ld_o(2'd1));
        step("lu_rs2_done", idle(), run_o(3'd0, 3'd0));

        // Redirect with one extra flush cycle; second redirect ignored
        step("redir", rd, fl_o(2'd0));
        step("redir_in_flush", rd, fl_o(2'd2));
        step("redir_done", idle(), run_o(3'd0, 3'd0));
        v = lu; v.redirect = 1;
        step("redir_over_lu", v, fl_o(2'd0));
        step("redir_over_lu_fl", idle(), fl_o(2'd2));
        step("redir_over_lu_done", idle(), run_o(3'd0, 3'd0));
        step("lu_then_redir", lu, ld_o(2'd0));
        step("redir_in_ldstall", rd, fl_o(2'd1));
        step("redir_cancel_fl", idle(), fl_o(2'd2));
        step("redir_cancel_done", idle(), run_o(3'd0, 3'd0));

        // Memory wait inside a load stall
        step("mw_lu", lu, ld_o(2'd0));
        for (int unsigned k = 0; k < 3; k++) step("mw_wait", w, wt_o(3'd0));
        step("mw_release_ldstall", r, ld_o(2'd1));
        step("mw_back_run", idle(), run_o(3'd0, 3'd0));

        // Redirect held during a memory wait, forwarding selects frozen
        v = w; v.redirect = 1; v.ex_reg_we = 1; v.ex_rd = 5; v.ex_rs1 = 5;
        step("mw_fwd_first", v, wt_o(3'd2));
        v = w; v.redirect = 1;
        step("mw_fwd_hold", v, wt_o(3'd2));
        v = r; v.redirect = 1;
        step("mw_redir_apply", v, fl_o(2'd0));
        step("mw_redir_flush", idle(), fl_o(2'd2));
        step("mw_redir_done", idle(), run_o(3'd0, 3'd0));

        // Reset mid-flush and mid-stall
        step("rf_redir", rd, fl_o(2'd0));
        v = idle(); v.rst = 1'b0;
        step("rf_reset", v, rst_o());
        step("rf_release", idle(), rst_o());
        step("rf_run", idle(), run_o(3'd0, 3'd0));
        step("rs_lu", lu, ld_o(2'd0));
        v = idle(); v.rst = 1'b0;
        step("rs_reset", v, rst_o());
        step("rs_release", idle(), rst_o());
        step("rs_run_no_bubble", idle(), run_o(3'd0, 3'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
